// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Purpose  : Round-robin owner of the framebuffer RAM write port, shared by
//            Avalon host writes and a clear/fill sweep engine.
// Options  : FB_CLEAR_VSYNC_EN - hold the sweep in ARM until a vsync_n fall.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int FB_WORDS = 9600,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [DATA_W-1:0] host_writedata,
  output logic              host_waitrequest,
  input  logic              clr_start,
  input  logic              clr_abort,
  input  logic [DATA_W-1:0] clr_pattern,
  input  logic              vsync_n,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_wraddress,
  output logic [DATA_W-1:0] fb_data
);

  localparam logic [ADDR_W-1:0] C_LAST_WORD = ADDR_W'(FB_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic              rr_eng_q, rr_eng_d;
  logic              fb_wren_q, fb_wren_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0] fb_data_q, fb_data_d;

  logic w_eng_req;
  logic w_grant_host;
  logic w_grant_eng;
  logic w_host_in_range;
  logic w_start_ok;
  logic w_arm_go;

`ifdef FB_CLEAR_VSYNC_EN
  // [1:0] synchroniser, [2] previous synchronised sample for edge detect
  logic [2:0] vs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 3'b111;
    end else begin
      vs_q <= {vs_q[1:0], vsync_n};
    end
  end

  assign w_arm_go = vs_q[2] & ~vs_q[1];
`else
  logic w_unused_vsync;
  assign w_unused_vsync = vsync_n;
  assign w_arm_go       = 1'b1;
`endif

  // An abort withdraws the engine request in the same cycle, so no word
  // beyond the last one already granted is written.
  assign w_eng_req        = (state_q == ST_SWEEP) & ~clr_abort;
  assign w_grant_host     = host_write & (~w_eng_req | ~rr_eng_q);
  assign w_grant_eng      = w_eng_req & (~host_write | rr_eng_q);
  assign w_host_in_range  = (host_address <= C_LAST_WORD);
  assign w_start_ok       = (state_q == ST_IDLE) & clr_start & ~clr_abort;

  assign host_waitrequest = host_write & ~w_grant_host;
  assign clr_busy         = (state_q != ST_IDLE);
  assign clr_done         = (state_q == ST_DONE);
  assign fb_wren          = fb_wren_q;
  assign fb_wraddress     = fb_addr_q;
  assign fb_data          = fb_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start_ok) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (clr_abort)     state_d = ST_IDLE;
        else if (w_arm_go) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (clr_abort)                                   state_d = ST_IDLE;
        else if (w_grant_eng && (cnt_q == C_LAST_WORD))  state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    rr_eng_d  = rr_eng_q;
    fb_wren_d = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;

    if (w_start_ok) begin
      cnt_d     = '0;
      pattern_d = clr_pattern;
    end else if (w_grant_eng && (cnt_q != C_LAST_WORD)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Contested cycle: the pointer moves to whichever side just lost.
    if (host_write && w_eng_req) begin
      rr_eng_d = w_grant_host;
    end

    if (w_grant_eng) begin
      fb_wren_d = 1'b1;
      fb_addr_d = cnt_q;
      fb_data_d = pattern_q;
    end else if (w_grant_host && w_host_in_range) begin
      fb_wren_d = 1'b1;
      fb_addr_d = host_address;
      fb_data_d = host_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pattern_q <= '0;
      rr_eng_q  <= 1'b0;
      fb_wren_q <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      rr_eng_q  <= rr_eng_d;
      fb_wren_q <= fb_wren_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_arbiter
// Purpose  : Directed self-checking bench; small (16-word) and full-size DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          host_write = 1'b0;
  logic [AW-1:0] host_address = '0;
  logic [DW-1:0] host_writedata = '0;
  logic          clr_start = 1'b0;
  logic          clr_abort = 1'b0;
  logic [DW-1:0] clr_pattern = '0;
  logic          vsync_n = 1'b1;
  logic          tie0 = 1'b0;

  logic          s_wait, s_busy, s_done, s_wren;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic          b_wait, b_busy, b_done, b_wren;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  fb_write_arbiter #(.FB_WORDS(16), .ADDR_W(AW), .DATA_W(DW)) u_small (
    .clk(clk), .reset_n(reset_n),
    .host_write(host_write), .host_address(host_address),
    .host_writedata(host_writedata), .host_waitrequest(s_wait),
    .clr_start(clr_start), .clr_abort(clr_abort), .clr_pattern(clr_pattern),
    .vsync_n(vsync_n), .clr_busy(s_busy), .clr_done(s_done),
    .fb_wren(s_wren), .fb_wraddress(s_addr), .fb_data(s_data)
  );

  fb_write_arbiter #(.FB_WORDS(9600), .ADDR_W(AW), .DATA_W(DW)) u_big (
    .clk(clk), .reset_n(reset_n),
    .host_write(host_write), .host_address(host_address),
    .host_writedata(host_writedata), .host_waitrequest(b_wait),
    .clr_start(tie0), .clr_abort(tie0), .clr_pattern(clr_pattern),
    .vsync_n(vsync_n), .clr_busy(b_busy), .clr_done(b_done),
    .fb_wren(b_wren), .fb_wraddress(b_addr), .fb_data(b_data)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_wait;
    logic          exp_wren;
  } vec_t;

  vec_t vecs[6];

  // Records of one stimulus window on the small DUT
  int            eng_addr[$];
  logic [DW-1:0] eng_data[$];
  int            host_addr_q[$];
  logic [DW-1:0] host_data_q[$];
  int            done_cnt, done_cyc, last_eng_cyc, wait_cnt, wait_consec, host_acc;
  logic          busy_c0, busy_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic run(input int n, input bit host_on, input bit do_start, input bit dbl_start,
                     input int abort_at, input logic [DW-1:0] pat);
    bit acc = 1'b0;
    bit prev_wait = 1'b0;
    bit aborted = 1'b0;
    int k = 0;
    eng_addr.delete(); eng_data.delete(); host_addr_q.delete(); host_data_q.delete();
    done_cnt = 0; done_cyc = -1; last_eng_cyc = -1; wait_cnt = 0; wait_consec = 0; host_acc = 0;
    for (int c = 0; c < n; c++) begin
      if (acc) k++;
      clr_start      = (do_start && c == 0) || (dbl_start && c == 1);
      clr_pattern    = (c == 0) ? pat : 32'h1234_5678;
      clr_abort      = (abort_at != 0) && (eng_addr.size() == abort_at) && !aborted;
      if (clr_abort) aborted = 1'b1;
      host_write     = host_on;
      host_address   = AW'(k % 16);
      host_writedata = 32'hA000_0000 | 32'(k);
      #1;
      acc = host_write && !s_wait;
      if (acc) host_acc++;
      if (s_wait) begin
        wait_cnt++;
        if (prev_wait) wait_consec++;
      end
      prev_wait = s_wait;
      step();
      if (c == 0) busy_c0 = s_busy;
      if (s_wren) begin
        if (s_data == pat) begin
          eng_addr.push_back(int'(s_addr));
          eng_data.push_back(s_data);
          last_eng_cyc = c;
        end else begin
          host_addr_q.push_back(int'(s_addr));
          host_data_q.push_back(s_data);
        end
      end
      if (s_done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    clr_start = 1'b0; clr_abort = 1'b0; host_write = 1'b0;
    busy_end = s_busy;
  endtask

  task automatic check_eng_seq(input string tag, input int n_exp, input logic [DW-1:0] pat);
    check({tag, "_eng_count"}, 32'(eng_addr.size()), 32'(n_exp));
    for (int i = 0; i < eng_addr.size() && i < n_exp; i++) begin
      check({tag, "_eng_addr"}, 32'(eng_addr[i]), 32'(i));
      check({tag, "_eng_data"}, eng_data[i], pat);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 15'h0010, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 15'h0011, 32'h0BAD_F00D, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 15'h7FFF, 32'hCAFE_0001, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 15'h2580, 32'hCAFE_0002, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 15'h257F, 32'hCAFE_0003, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 15'h0000, 32'h1234_5678, 1'b0, 1'b1};

    // Reset state
    reset_n = 1'b0;
    step();
    check("rst_wren",  32'(s_wren), 32'd0);
    check("rst_addr",  32'(s_addr), 32'd0);
    check("rst_data",  s_data, 32'd0);
    check("rst_busy",  32'(s_busy), 32'd0);
    check("rst_done",  32'(s_done), 32'd0);
    check("rst_wait",  32'(s_wait), 32'd0);
    check("rst_bwren", 32'(b_wren), 32'd0);
    step();
    reset_n = 1'b1;

    // Host-only writes on the full-size instance
    for (int i = 0; i < 6; i++) begin
      host_write = vecs[i].wr; host_address = vecs[i].addr; host_writedata = vecs[i].data;
      #1;
      check($sformatf("vec%0d_wait", i), 32'(b_wait), 32'(vecs[i].exp_wait));
      step();
      check($sformatf("vec%0d_wren", i), 32'(b_wren), 32'(vecs[i].exp_wren));
      if (vecs[i].exp_wren) begin
        check($sformatf("vec%0d_addr", i), 32'(b_addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_data", i), b_data, vecs[i].data);
      end
    end
    host_write = 1'b0;
    step();
    check("host_idle_wren", 32'(b_wren), 32'd0);

    // Idle sweep, with a second start during ARM that must be ignored
    do_reset();
    run(24, 1'b0, 1'b1, 1'b1, 0, 32'hFFFF_FFFF);
    check("sweep_busy_after_start", 32'(busy_c0), 32'd1);
    check_eng_seq("sweep", 16, 32'hFFFF_FFFF);
    check("sweep_host_writes", 32'(host_addr_q.size()), 32'd0);
    check("sweep_done_count", 32'(done_cnt), 32'd1);
    check("sweep_done_with_last", 32'(done_cyc), 32'(last_eng_cyc));
    check("sweep_busy_end", 32'(busy_end), 32'd0);

    // Host writes every cycle during a sweep
    do_reset();
    run(45, 1'b1, 1'b1, 1'b0, 0, 32'h5A5A_5A5A);
    check_eng_seq("contest", 16, 32'h5A5A_5A5A);
    check("contest_wait_cycles", 32'(wait_cnt), 32'd16);
    check("contest_wait_back_to_back", 32'(wait_consec), 32'd0);
    check("contest_host_count", 32'(host_data_q.size()), 32'(host_acc));
    for (int j = 0; j < host_data_q.size(); j++) begin
      check("contest_host_data", host_data_q[j], 32'hA000_0000 | 32'(j));
      check("contest_host_addr", 32'(host_addr_q[j]), 32'(j % 16));
    end
    check("contest_done_count", 32'(done_cnt), 32'd1);

    // Abort after five engine writes, then restart
    do_reset();
    run(20, 1'b0, 1'b1, 1'b0, 5, 32'h0F0F_0F0F);
    check_eng_seq("abort", 5, 32'h0F0F_0F0F);
    check("abort_done_count", 32'(done_cnt), 32'd0);
    check("abort_busy_end", 32'(busy_end), 32'd0);
    run(24, 1'b0, 1'b1, 1'b0, 0, 32'h3333_3333);
    check_eng_seq("restart", 16, 32'h3333_3333);
    check("restart_done_count", 32'(done_cnt), 32'd1);

    // Start and abort together in IDLE
    clr_start = 1'b1; clr_abort = 1'b1; clr_pattern = 32'h7777_7777;
    step();
    clr_start = 1'b0; clr_abort = 1'b0;
    check("start_abort_busy", 32'(s_busy), 32'd0);
    step();
    step();
    check("start_abort_wren", 32'(s_wren), 32'd0);
    check("start_abort_busy2", 32'(s_busy), 32'd0);

    // Asynchronous reset mid-sweep
    run(8, 1'b0, 1'b1, 1'b0, 0, 32'hC3C3_C3C3);
    check("midrst_pre_wren", 32'(s_wren), 32'd1);
    #4;
    reset_n = 1'b0;
    #1;
    check("midrst_wren", 32'(s_wren), 32'd0);
    check("midrst_addr", 32'(s_addr), 32'd0);
    check("midrst_data", s_data, 32'd0);
    check("midrst_busy", 32'(s_busy), 32'd0);
    check("midrst_done", 32'(s_done), 32'd0);
    step();
    reset_n = 1'b1;
    run(20, 1'b0, 1'b0, 1'b0, 0, 32'hC3C3_C3C3);
    check("midrst_after_writes", 32'(eng_addr.size()), 32'd0);
    check("midrst_after_done", 32'(done_cnt), 32'd0);
    check("midrst_after_busy", 32'(busy_end), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
